// File: rtl/nios_sram_dma_pkg.sv
// Shared defaults and FSM state encoding for the on-chip SRAM DMA master.
package nios_sram_dma_pkg;
  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 20480;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/nios_sram_dma_master.sv
// Word-granular copy/fill engine driving an Avalon-MM on-chip SRAM slave.
// state | meaning: IDLE wait start | RD read src | RWAIT capture data | WR write dst | DONE pulse done
module nios_sram_dma_master
  import nios_sram_dma_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  input  logic [DATA_W-1:0]   fill_data,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
);
  localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W+2)'(NUM_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d, words_q, words_d, words_inc;
  logic              mode_q, mode_d, error_q, error_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W+1:0] src_end, dst_end;
  logic              reject;

  // One past the last word touched; must not exceed the SRAM size.
  assign src_end   = {2'b00, src_addr} + {1'b0, len};
  assign dst_end   = {2'b00, dst_addr} + {1'b0, len};
  assign reject    = (len != '0) && ((dst_end > LIMIT) || (!mode && (src_end > LIMIT)));
  assign words_inc = words_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      words_q <= words_d;
      mode_q  <= mode_d;
      error_q <= error_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    mode_d         = mode_q;
    words_d        = words_q;
    data_d         = data_q;
    error_d        = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reject) begin
            error_d = 1'b1;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len;
            mode_d  = mode;
            words_d = '0;
            // Fill pattern lives in the data register; copy overwrites it in RWAIT.
            data_d  = fill_data;
            if (len == '0)  state_d = S_DONE;
            else if (mode)  state_d = S_WR;
            else            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = src_q;
        state_d        = abort ? S_IDLE : S_RWAIT;
      end
      S_RWAIT: begin
        data_d  = avm_readdata;
        state_d = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_writedata  = data_q;
        words_d        = words_inc;
        src_d          = src_q + ADDR_W'(1);
        dst_d          = dst_q + ADDR_W'(1);
        if (abort)                   state_d = S_IDLE;
        else if (words_inc == len_q) state_d = S_DONE;
        else if (mode_q)             state_d = S_WR;
        else                         state_d = S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign error          = error_q;
  assign words_done     = words_q;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;
endmodule
